// File: rtl/record_unpacker_if.sv
// Valid/ready bundle for the record unpacker: packed records in, single fields out.
// valid/ready: a beat moves on a rising clk edge where valid && ready; payload is held while valid && !ready.
interface record_unpacker_if #(
    parameter int FIELD_W    = 8,
    parameter int NUM_FIELDS = 3,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_FIELDS*FIELD_W-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [FIELD_W-1:0]            out_field;
    logic [IDX_W-1:0]              out_index;
    logic                          out_last;
    logic [CNT_W-1:0]              rec_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_field, out_index, out_last, rec_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_field, out_index, out_last, rec_count
    );
endinterface

// File: rtl/record_unpacker.sv
// Splits one packed record into NUM_FIELDS fields, field 0 (LSBs) first,
// and counts fully emitted records.
module record_unpacker #(
    parameter int FIELD_W    = 8,
    parameter int NUM_FIELDS = 3,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    record_unpacker_if.slave      bus,
    output logic                  o_dbg_emit
);
    localparam int REC_W = NUM_FIELDS * FIELD_W;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [REC_W-1:0]   r_rec;
    logic [FIELD_W-1:0] r_field;
    logic [IDX_W-1:0]   r_index;
    logic               r_last;
    logic [CNT_W-1:0]   r_count;

    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_rec_done;
    logic [IDX_W-1:0]   w_next_idx;
    logic [FIELD_W-1:0] w_next_field;

    assign w_out_xfer = (r_state == S_EMIT) && bus.out_ready;
    assign w_rec_done = w_out_xfer && r_last;
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_next_idx = r_index + IDX_W'(1);

    // A new record may enter only when idle or as the last field leaves.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                w_in_ready = bus.out_ready && r_last;
                if (w_rec_done && !bus.in_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) w_in_ready = 1'b0;
    end

    always_comb begin
        w_next_field = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (int'(w_next_idx) == k) w_next_field = r_rec[k*FIELD_W +: FIELD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rec   <= '0;
            r_field <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_in_xfer) begin
                r_rec   <= bus.in_data;
                r_field <= bus.in_data[FIELD_W-1:0];
                r_index <= '0;
                r_last  <= (NUM_FIELDS == 1);
            end else if (w_out_xfer && !r_last) begin
                r_field <= w_next_field;
                r_index <= w_next_idx;
                r_last  <= (int'(w_next_idx) == NUM_FIELDS - 1);
            end
            if (w_rec_done) r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_EMIT);
    assign bus.out_field = r_field;
    assign bus.out_index = r_index;
    assign bus.out_last  = (r_state == S_EMIT) && r_last;
    assign bus.rec_count = r_count;
    assign o_dbg_emit    = (r_state == S_EMIT);
endmodule

// File: tb/tb_record_unpacker.sv
// Bench for record_unpacker: queue-based field-stream model checked every cycle,
// directed scenarios with literal expectations, random traffic, and a one-field instance.
module tb_record_unpacker;
    localparam int FIELD_W    = 8;
    localparam int NUM_FIELDS = 3;
    localparam int IDX_W      = 2;
    localparam int CNT_W      = 4;
    localparam int REC_W      = FIELD_W * NUM_FIELDS;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    logic dbg_emit;
    logic dbg_emit1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    record_unpacker_if #(.FIELD_W(FIELD_W), .NUM_FIELDS(NUM_FIELDS), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();
    record_unpacker_if #(.FIELD_W(4), .NUM_FIELDS(1), .IDX_W(1), .CNT_W(4)) bus1 ();

    record_unpacker #(.FIELD_W(FIELD_W), .NUM_FIELDS(NUM_FIELDS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_dbg_emit(dbg_emit)
    );
    record_unpacker #(.FIELD_W(4), .NUM_FIELDS(1), .IDX_W(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .o_dbg_emit(dbg_emit1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the queue holds every field still owed downstream, head = field on the bus.
    typedef struct packed {
        logic [FIELD_W-1:0] f;
        logic [IDX_W-1:0]   i;
        logic               l;
    } item_t;

    item_t            m_q[$];
    item_t            m_hold = '0;
    logic [CNT_W-1:0] m_cnt  = '0;
    logic [7:0]       log_q[$];

    function automatic logic m_in_ready();
        return !rst && (m_q.size() == 0 || (bus.out_ready && m_q.size() == 1));
    endfunction

    always @(posedge clk) begin
        logic acc;
        acc = bus.in_valid && m_in_ready();
        if (rst) begin
            m_q.delete();
            m_hold = '0;
            m_cnt  = '0;
        end else begin
            if (m_q.size() > 0 && bus.out_ready) begin
                m_hold = m_q.pop_front();
                if (m_hold.l) m_cnt = m_cnt + CNT_W'(1);
            end
            if (acc) begin
                for (int k = 0; k < NUM_FIELDS; k++)
                    m_q.push_back(item_t'{f: bus.in_data[k*FIELD_W +: FIELD_W], i: IDX_W'(k), l: (k == NUM_FIELDS - 1)});
            end
            if (m_q.size() > 0) m_hold = m_q[0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
            check("out_field", 32'(bus.out_field), 32'(m_hold.f));
            check("out_index", 32'(bus.out_index), 32'(m_hold.i));
            check("out_last",  32'(bus.out_last),  32'(m_hold.l && m_q.size() > 0));
            check("in_ready",  32'(bus.in_ready),  32'(m_in_ready()));
            check("rec_count", 32'(bus.rec_count), 32'(m_cnt));
            if (bus.out_valid && bus.out_ready) log_q.push_back(bus.out_field);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send_record(input logic [REC_W-1:0] d);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            done = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = REC_W'($urandom);
        check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 50 && !idle; n++) begin
            #1;
            idle = !bus.out_valid;
            if (!idle) step();
        end
        check("wait_idle", 32'(idle), 32'd1);
    endtask

    function automatic logic [7:0] pop_log();
        if (log_q.size() > 0) return log_q.pop_front();
        return 8'hxx;
    endfunction

    task automatic check_rec(input string name, input logic [REC_W-1:0] rec);
        for (int k = 0; k < NUM_FIELDS; k++)
            check(name, 32'(pop_log()), 32'(rec[k*FIELD_W +: FIELD_W]));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic unpack
        bus.out_ready = 1'b1;
        send_record(24'hCC_BB_AA);
        check("basic_first_field", 32'(bus.out_field), 32'hAA);
        wait_idle();
        check("basic_log_size", 32'(log_q.size()), 32'd3);
        check_rec("basic_field", 24'hCC_BB_AA);
        check("basic_count", 32'(bus.rec_count), 32'd1);
        check("model_count", 32'(m_cnt), 32'd1);
        check("basic_idle", 32'(dbg_emit), 32'd0);

        // Back-to-back records
        pulse_reset();
        log_q.delete();
        send_record(24'h03_02_01);
        send_record(24'h06_05_04);
        wait_idle();
        check("b2b_log_size", 32'(log_q.size()), 32'd6);
        check_rec("b2b_field_a", 24'h03_02_01);
        check_rec("b2b_field_b", 24'h06_05_04);
        check("b2b_count", 32'(bus.rec_count), 32'd2);

        // Backpressure 1,0,0,1,1
        log_q.delete();
        send_record(24'hCC_BB_AA);
        bus.out_ready = 1'b1; step();
        bus.out_ready = 1'b0; step();
        check("bp_hold1", 32'(bus.out_field), 32'hBB);
        bus.in_data = 24'h5A_5A_5A;
        step();
        check("bp_hold2", 32'(bus.out_field), 32'hBB);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1; step();
        check("bp_last", 32'(bus.out_field), 32'hCC);
        step();
        wait_idle();
        check("bp_log_size", 32'(log_q.size()), 32'd3);
        check_rec("bp_field", 24'hCC_BB_AA);
        check("bp_count", 32'(bus.rec_count), 32'd3);

        // Reset mid-record
        log_q.delete();
        send_record(24'hCC_BB_AA);
        step();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h77_66_55;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.rec_count), 32'd0);
        log_q.delete();
        send_record(24'h11_22_33);
        check("rst_new_index", 32'(bus.out_index), 32'd0);
        wait_idle();
        check_rec("rst_field", 24'h11_22_33);

        // Counter wrap at CNT_W=4
        pulse_reset();
        for (int r = 1; r <= 17; r++) begin
            send_record(REC_W'($urandom));
            wait_idle();
            if (r == 15) check("wrap_15", 32'(bus.rec_count), 32'd15);
            if (r == 16) check("wrap_16", 32'(bus.rec_count), 32'd0);
            if (r == 17) check("wrap_17", 32'(bus.rec_count), 32'd1);
        end

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = REC_W'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        // One-field instance
        pulse_reset();
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 4'h5;
        #1;
        check("nf1_ready_idle", 32'(bus1.in_ready), 32'd1);
        step();
        check("nf1_field0", 32'(bus1.out_field), 32'h5);
        check("nf1_valid0", 32'(bus1.out_valid), 32'd1);
        check("nf1_last0", 32'(bus1.out_last), 32'd1);
        check("nf1_index0", 32'(bus1.out_index), 32'd0);
        check("nf1_ready_emit", 32'(bus1.in_ready), 32'd1);
        bus1.in_data = 4'hA;
        step();
        bus1.in_valid = 1'b0;
        check("nf1_field1", 32'(bus1.out_field), 32'hA);
        check("nf1_last1", 32'(bus1.out_last), 32'd1);
        check("nf1_index1", 32'(bus1.out_index), 32'd0);
        check("nf1_count1", 32'(bus1.rec_count), 32'd1);
        step();
        check("nf1_valid_end", 32'(bus1.out_valid), 32'd0);
        check("nf1_count2", 32'(bus1.rec_count), 32'd2);
        check("nf1_idle", 32'(dbg_emit1), 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
